// File: rtl/phase_sequencer.sv
// phase_sequencer: produces the one-hot phase code (IF/DE/EX/WB) for the
// combinational controller. It provides run/stop/single-step console control,
// memory wait-state stalling with a timeout in IF and WB, and a count of
// retired instructions.
// Optional feature macro: PHASE_SEQ_BRKPT_EN enables halting on a PC
// breakpoint at the WB->IF boundary. When it is undefined, pc, brk_addr and
// brk_en are ignored and brk_hit is tied to 0.
//
// Memory handshake: mem_access acts as the request (valid) and mem_ready as
// the completion (ready). An access completes in any cycle where both are 1.
// A phase with mem_access=0 never waits. A phase with mem_access=1 and
// mem_ready=0 holds, and each held cycle counts toward the timeout.
module phase_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TMO_MAX = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             stop_req,
    input  logic             step_req,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic [31:0]      pc,
    input  logic [31:0]      brk_addr,
    input  logic             brk_en,
    output logic [3:0]       cstate,
    output logic             running,
    output logic             bus_err,
    output logic             brk_hit,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_HALT = 3'd0,
        S_IF   = 3'd1,
        S_DE   = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4
    } state_t;

    localparam logic [7:0] TMO_CNT = 8'(TMO_MAX);

    state_t     state;
    logic       continuous;
    logic       stop_pend;
    logic [7:0] stall_cnt;

    logic mem_phase;
    logic stalled;
    logic timeout;
    logic start;
    logic stop_now;
    logic wb_done;
    logic brk_match;

    // Phase code for a given state; HALT maps to all zeros.
    function automatic logic [3:0] phase_code(input state_t s);
        case (s)
            S_IF:    phase_code = 4'b0001;
            S_DE:    phase_code = 4'b0010;
            S_EX:    phase_code = 4'b0100;
            S_WB:    phase_code = 4'b1000;
            default: phase_code = 4'b0000;
        endcase
    endfunction

    // Only IF and WB perform memory accesses that can be held by wait states.
    assign mem_phase = (state == S_IF) || (state == S_WB);
    assign stalled   = mem_phase && mem_access && !mem_ready;
    // Timeout fires only after TMO_MAX held cycles AND memory still not ready.
    assign timeout   = stalled && (stall_cnt == TMO_CNT);
    // Stop beats run and step; run beats step (continuous flag follows run_req).
    assign start     = (state == S_HALT) && !stop_req && (run_req || step_req);
    // A stop raised in the WB exit cycle itself still halts at that boundary.
    assign stop_now  = stop_pend || stop_req;
    assign wb_done   = (state == S_WB) && !stalled;

`ifdef PHASE_SEQ_BRKPT_EN
    // pc already holds the next PC at the WB exit, so compare it directly.
    assign brk_match = brk_en && (pc == brk_addr);

    // Sticky breakpoint flag: set when a WB->IF transition is diverted to HALT,
    // cleared when execution restarts from HALT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            brk_hit <= 1'b0;
        end else if (start) begin
            brk_hit <= 1'b0;
        end else if (wb_done && continuous && !stop_now && brk_match) begin
            brk_hit <= 1'b1;
        end
    end
`else
    logic unused_brk;
    assign unused_brk = ^{pc, brk_addr, brk_en};
    assign brk_match  = 1'b0;
    assign brk_hit    = 1'b0;
`endif

    // Phase FSM with registered phase code, run control, stall timer and counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_HALT;
            cstate     <= 4'b0000;
            running    <= 1'b0;
            continuous <= 1'b0;
            stop_pend  <= 1'b0;
            bus_err    <= 1'b0;
            stall_cnt  <= 8'd0;
            instr_cnt  <= '0;
        end else begin
            // Record a stop request while executing; HALT entries below clear it.
            if (stop_req && (state != S_HALT)) begin
                stop_pend <= 1'b1;
            end

            case (state)
                S_HALT: begin
                    if (start) begin
                        state      <= S_IF;
                        cstate     <= phase_code(S_IF);
                        running    <= 1'b1;
                        continuous <= run_req;
                        bus_err    <= 1'b0;
                        stall_cnt  <= 8'd0;
                    end
                end

                S_IF: begin
                    if (timeout) begin
                        state     <= S_HALT;
                        cstate    <= phase_code(S_HALT);
                        running   <= 1'b0;
                        bus_err   <= 1'b1;
                        stop_pend <= 1'b0;
                        stall_cnt <= 8'd0;
                    end else if (stalled) begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end else begin
                        state     <= S_DE;
                        cstate    <= phase_code(S_DE);
                        stall_cnt <= 8'd0;
                    end
                end

                S_DE: begin
                    state     <= S_EX;
                    cstate    <= phase_code(S_EX);
                    stall_cnt <= 8'd0;
                end

                S_EX: begin
                    state     <= S_WB;
                    cstate    <= phase_code(S_WB);
                    stall_cnt <= 8'd0;
                end

                S_WB: begin
                    if (timeout) begin
                        state     <= S_HALT;
                        cstate    <= phase_code(S_HALT);
                        running   <= 1'b0;
                        bus_err   <= 1'b1;
                        stop_pend <= 1'b0;
                        stall_cnt <= 8'd0;
                    end else if (stalled) begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end else begin
                        instr_cnt <= instr_cnt + CNT_W'(1);
                        stall_cnt <= 8'd0;
                        if (continuous && !stop_now && !brk_match) begin
                            state  <= S_IF;
                            cstate <= phase_code(S_IF);
                        end else begin
                            state     <= S_HALT;
                            cstate    <= phase_code(S_HALT);
                            running   <= 1'b0;
                            stop_pend <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= S_HALT;
                    cstate    <= phase_code(S_HALT);
                    running   <= 1'b0;
                    stop_pend <= 1'b0;
                    stall_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule
